// File: rtl/ex_mem_alu_stage_pkg.sv
// Shared types and defaults for the execute stage and its EX/MEM register.
package ex_mem_alu_stage_pkg;

    localparam int unsigned XlenDefault = 32;

    typedef enum logic [3:0] {
        AluAdd  = 4'b0000,
        AluSub  = 4'b0001,
        AluAnd  = 4'b0010,
        AluOr   = 4'b0011,
        AluXor  = 4'b0100,
        AluSll  = 4'b0101,
        AluSrl  = 4'b0110,
        AluSra  = 4'b0111,
        AluSlt  = 4'b1000,
        AluSltu = 4'b1001,
        AluBeq  = 4'b1010,
        AluBne  = 4'b1011,
        AluBlt  = 4'b1100,
        AluBge  = 4'b1101,
        AluBltu = 4'b1110,
        AluBgeu = 4'b1111
    } alu_op_e;

    // Ops 1010..1111 are branch compares.
    function automatic logic is_branch_op(logic [3:0] op);
        return op[3] & (op[2] | op[1]);
    endfunction

endpackage

// File: rtl/ex_mem_alu_stage_alu_core.sv
// Combinational ALU: arithmetic/logic result plus branch comparison outcome.
module alu_core
    import ex_mem_alu_stage_pkg::*;
#(
    parameter int unsigned XLEN = XlenDefault
) (
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] result,
    output logic            cmp_true
);

    logic [4:0] shamt;
    logic       eq;
    logic       lt_s;
    logic       lt_u;

    assign shamt = b[4:0];
    assign eq    = (a == b);
    assign lt_s  = ($signed(a) < $signed(b));
    assign lt_u  = (a < b);

    always_comb begin
        result   = '0;
        cmp_true = 1'b0;
        unique case (alu_op_e'(alu_op))
            AluAdd:  result = a + b;
            AluSub:  result = a - b;
            AluAnd:  result = a & b;
            AluOr:   result = a | b;
            AluXor:  result = a ^ b;
            AluSll:  result = a << shamt;
            AluSrl:  result = a >> shamt;
            AluSra:  result = $signed(a) >>> shamt;
            AluSlt:  result = {{(XLEN-1){1'b0}}, lt_s};
            AluSltu: result = {{(XLEN-1){1'b0}}, lt_u};
            AluBeq:  cmp_true = eq;
            AluBne:  cmp_true = ~eq;
            AluBlt:  cmp_true = lt_s;
            AluBge:  cmp_true = ~lt_s;
            AluBltu: cmp_true = lt_u;
            AluBgeu: cmp_true = ~lt_u;
            default: begin
                result   = '0;
                cmp_true = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ex_mem_alu_stage.sv
// Execute stage: ALU and branch resolution feeding the EX/MEM pipeline register.
module ex_mem_alu_stage
    import ex_mem_alu_stage_pkg::*;
#(
    parameter int unsigned XLEN       = XlenDefault,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [3:0]            alu_op,
    input  logic [XLEN-1:0]       operand_a,
    input  logic [XLEN-1:0]       operand_b,
    input  logic [XLEN-1:0]       store_data_in,
    input  logic [XLEN-1:0]       pc_in,
    input  logic [XLEN-1:0]       imm_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    output logic                  out_valid,
    output logic [XLEN-1:0]       alu_result,
    output logic [XLEN-1:0]       store_data,
    output logic [REG_ADDR_W-1:0] rd_out,
    output logic                  reg_write,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  branch_taken,
    output logic [XLEN-1:0]       branch_target
);

    logic [XLEN-1:0] alu_res;
    logic            cmp_true;
    logic            is_branch;

    alu_core #(
        .XLEN(XLEN)
    ) u_alu_core (
        .alu_op  (alu_op),
        .a       (operand_a),
        .b       (operand_b),
        .result  (alu_res),
        .cmp_true(cmp_true)
    );

    assign is_branch = is_branch_op(alu_op);

    logic                  valid_q;
    logic [XLEN-1:0]       result_q;
    logic [XLEN-1:0]       store_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic                  reg_write_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic                  taken_q;
    logic [XLEN-1:0]       target_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            result_q    <= '0;
            store_q     <= '0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            taken_q     <= 1'b0;
            target_q    <= '0;
        end else if (flush || (!stall && !in_valid)) begin
            // Bubble: drop controls, leave data fields as they were.
            valid_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            taken_q     <= 1'b0;
        end else if (stall) begin
            // A held redirect must not fire a second time.
            taken_q <= 1'b0;
        end else begin
            valid_q     <= 1'b1;
            result_q    <= alu_res;
            store_q     <= store_data_in;
            rd_q        <= rd_in;
            reg_write_q <= reg_write_in & ~is_branch;
            mem_read_q  <= mem_read_in & ~is_branch;
            mem_write_q <= mem_write_in & ~is_branch;
            taken_q     <= cmp_true;
            target_q    <= pc_in + imm_in;
        end
    end

    assign out_valid     = valid_q;
    assign alu_result    = result_q;
    assign store_data    = store_q;
    assign rd_out        = rd_q;
    assign reg_write     = reg_write_q & valid_q;
    assign mem_read      = mem_read_q & valid_q;
    assign mem_write     = mem_write_q & valid_q;
    assign branch_taken  = taken_q & valid_q;
    assign branch_target = target_q;

endmodule

// File: tb/tb_ex_mem_alu_stage.sv
// Directed plus randomized checks of the execute stage against a queue-based scoreboard.
module tb_ex_mem_alu_stage;

    logic        clk = 1'b0;
    logic        reset, in_valid, stall, flush;
    logic [3:0]  alu_op;
    logic [31:0] operand_a, operand_b, store_data_in, pc_in, imm_in;
    logic [4:0]  rd_in;
    logic        reg_write_in, mem_read_in, mem_write_in;
    logic        out_valid, reg_write, mem_read, mem_write, branch_taken;
    logic [31:0] alu_result, store_data, branch_target;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    ex_mem_alu_stage #(
        .XLEN      (32),
        .REG_ADDR_W(5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .stall        (stall),
        .flush        (flush),
        .alu_op       (alu_op),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .store_data_in(store_data_in),
        .pc_in        (pc_in),
        .imm_in       (imm_in),
        .rd_in        (rd_in),
        .reg_write_in (reg_write_in),
        .mem_read_in  (mem_read_in),
        .mem_write_in (mem_write_in),
        .out_valid    (out_valid),
        .alu_result   (alu_result),
        .store_data   (store_data),
        .rd_out       (rd_out),
        .reg_write    (reg_write),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .branch_taken (branch_taken),
        .branch_target(branch_target)
    );

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];
    exp_t model = '0;
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [31:0] ref_result(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic [63:0] ext;
        ext = {{32{a[31]}}, a} >> b[4:0];
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << b[4:0];
            4'd6:    return a >> b[4:0];
            4'd7:    return ext[31:0];
            4'd8:    return {31'd0, (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)};
            4'd9:    return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_taken(logic [3:0] op, logic [31:0] a, logic [31:0] b);
        logic slt;
        slt = (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
        case (op)
            4'd10:   return a == b;
            4'd11:   return a != b;
            4'd12:   return slt;
            4'd13:   return !slt;
            4'd14:   return a < b;
            4'd15:   return !(a < b);
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Drive one cycle of inputs and push the expected post-edge register state.
    task automatic drive(input logic r, input logic st, input logic fl, input logic iv,
                         input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [4:0] rd, input logic rw, input logic mr, input logic mw);
        logic br;
        reset = r; stall = st; flush = fl; in_valid = iv; alu_op = op;
        operand_a = a; operand_b = b; store_data_in = sd; pc_in = pc; imm_in = imm;
        rd_in = rd; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
        br = (op >= 4'd10);
        if (r) begin
            model = '0;
        end else if (fl || (!st && !iv)) begin
            model.valid = 0; model.rw = 0; model.mr = 0; model.mw = 0; model.taken = 0;
        end else if (st) begin
            model.taken = 0;
        end else begin
            model.valid  = 1;
            model.result = ref_result(op, a, b);
            model.sdata  = sd;
            model.rd     = rd;
            model.rw     = rw && !br;
            model.mr     = mr && !br;
            model.mw     = mw && !br;
            model.taken  = ref_taken(op, a, b);
            model.target = pc + imm;
        end
        exp_q.push_back(model);
    endtask

    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = exp_q.pop_front();
            chk("out_valid", {31'd0, out_valid}, {31'd0, e.valid});
            chk("alu_result", alu_result, e.result);
            chk("store_data", store_data, e.sdata);
            chk("rd_out", {27'd0, rd_out}, {27'd0, e.rd});
            chk("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
            chk("mem_read", {31'd0, mem_read}, {31'd0, e.mr});
            chk("mem_write", {31'd0, mem_write}, {31'd0, e.mw});
            chk("branch_taken", {31'd0, branch_taken}, {31'd0, e.taken});
            chk("branch_target", branch_target, e.target);
        end
    endtask

    initial begin
        // Reset held two cycles with a live instruction presented.
        drive(1, 0, 0, 1, 4'd0, 32'd9, 32'd9, 32'd1, 32'h40, 32'h4, 5'd3, 1, 0, 0);
        tick_check();
        drive(1, 0, 0, 1, 4'd0, 32'd9, 32'd9, 32'd1, 32'h40, 32'h4, 5'd3, 1, 0, 0);
        tick_check();
        chk("reset_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_rw", {31'd0, reg_write}, 32'd0);

        // SUB 5-7 wraps.
        drive(0, 0, 0, 1, 4'd1, 32'd5, 32'd7, 32'h55, 32'h0, 32'h0, 5'd1, 1, 0, 0);
        tick_check();
        chk("sub_const", alu_result, 32'hFFFF_FFFE);

        drive(0, 0, 0, 1, 4'd7, 32'h8000_0000, 32'd4, 32'h0, 32'h0, 32'h0, 5'd2, 1, 0, 0);
        tick_check();
        chk("sra_const", alu_result, 32'hF800_0000);

        drive(0, 0, 0, 1, 4'd9, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0, 0);
        tick_check();
        chk("sltu_const", alu_result, 32'd1);
        drive(0, 0, 0, 1, 4'd8, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 5'd4, 1, 0, 0);
        tick_check();
        chk("slt_const", alu_result, 32'd0);

        // ADD and target wrap.
        drive(0, 0, 0, 1, 4'd0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'hFFFF_FFF0, 32'h20, 5'd5, 1, 0, 1);
        tick_check();

        // BNE taken with reg_write_in set; controls must be suppressed.
        drive(0, 0, 0, 1, 4'd11, 32'd3, 32'd4, 32'h0, 32'h100, 32'h20, 5'd6, 1, 1, 1);
        tick_check();
        chk("bne_taken", {31'd0, branch_taken}, 32'd1);
        chk("bne_target", branch_target, 32'h120);
        drive(0, 0, 0, 0, 4'd0, 32'd0, 32'd0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 0);
        tick_check();

        // Taken BEQ then three stall cycles with changing inputs.
        drive(0, 0, 0, 1, 4'd10, 32'd7, 32'd7, 32'h0, 32'h200, 32'h8, 5'd9, 0, 0, 0);
        tick_check();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 4'd0, 32'd100 + i, 32'd1, 32'hA, 32'h0, 32'h0, 5'd12, 1, 0, 0);
            tick_check();
            chk("stall_pulse", {31'd0, branch_taken}, 32'd0);
            chk("stall_rd", {27'd0, rd_out}, 32'd9);
        end

        // Flush wins over stall for an incoming load.
        drive(0, 0, 0, 1, 4'd0, 32'd8, 32'd4, 32'h0, 32'h0, 32'h0, 5'd10, 1, 1, 0);
        tick_check();
        drive(0, 1, 1, 1, 4'd0, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0, 5'd11, 1, 1, 0);
        tick_check();
        chk("flush_mr", {31'd0, mem_read}, 32'd0);

        // Randomized mix across all operations.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a, b;
            a = $urandom();
            b = (i % 4 == 0) ? a : $urandom();
            drive(0, ($urandom_range(0, 4) == 0), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) != 0), 4'($urandom_range(0, 15)), a, b, $urandom(),
                  $urandom(), $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick_check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
